// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes,
// controller states and the lane width.
package mem_pkg;

   localparam int BYTE = 8;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-cache signals of the load/store unit.
// master = datapath plus cache side, slave = the unit itself.
interface mem_access_unit_if #(
   parameter int WIDTH     = 32,
   parameter int WIDTH_ADD = 32
);

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [1:0]           req_size;
   logic                 req_unsigned;
   logic [WIDTH_ADD-1:0] req_addr;
   logic [WIDTH-1:0]     req_wdata;
   logic                 resp_valid;
   logic [WIDTH-1:0]     resp_rdata;
   logic                 resp_err;
   logic [WIDTH_ADD-1:0] dc_addr;
   logic [WIDTH-1:0]     dc_wdata;
   logic                 dc_we;
   logic [WIDTH-1:0]     dc_rdata;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, dc_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, dc_addr, dc_wdata, dc_we
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, dc_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, dc_addr, dc_wdata, dc_we
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: merges store data into an old word and
// extracts/extends load data from a cache word (32-bit words, 8-bit lanes).
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       size,
   input  logic [1:0]       addr_lo,
   input  logic             is_unsigned,
   input  logic [WIDTH-1:0] word,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] merged,
   output logic [WIDTH-1:0] rdata
);

   logic [4:0]        b_off;
   logic [4:0]        h_off;
   logic [BYTE-1:0]   lane_b;
   logic [2*BYTE-1:0] lane_h;

   assign b_off  = {addr_lo, 3'b000};
   assign h_off  = {addr_lo[1], 4'b0000};
   assign lane_b = word[b_off +: BYTE];
   assign lane_h = word[h_off +: 2*BYTE];

   always_comb begin
      merged = word;
      rdata  = word;
      case (size)
         SZ_BYTE: begin
            merged[b_off +: BYTE] = wdata[BYTE-1:0];
            rdata = {{(WIDTH-BYTE){~is_unsigned & lane_b[BYTE-1]}}, lane_b};
         end
         SZ_HALF: begin
            merged[h_off +: 2*BYTE] = wdata[2*BYTE-1:0];
            rdata = {{(WIDTH-2*BYTE){~is_unsigned & lane_h[2*BYTE-1]}}, lane_h};
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: validates requests, runs loads and
// read-modify-write sub-word stores against a word-wide data cache.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int WIDTH_ADD = 32,
   parameter int SIZE      = 32
) (
   input logic               clk,
   input logic               rst_n,
   mem_access_unit_if.slave  bus
);

   state_t               state_q, state_d;
   logic                 wr_q, uns_q, err_q;
   logic [1:0]           size_q, lo_q;
   logic [WIDTH-1:0]     wdata_q, rdata_q, dc_wdata_q;
   logic [WIDTH_ADD-1:0] dc_addr_q;
   logic [WIDTH-1:0]     merged, extracted;
   logic                 accept, acc_err;

   // Aligned address + 3 is the last byte touched; computed one bit wider
   // so addresses near the top of the space cannot wrap into range.
   function automatic logic req_error(input logic [1:0] sz, input logic [WIDTH_ADD-1:0] a);
      logic [WIDTH_ADD:0] last;
      last = {1'b0, a[WIDTH_ADD-1:2], 2'b11};
      return (sz == 2'd3) || (sz == SZ_HALF && a[0]) ||
             (sz == SZ_WORD && a[1:0] != 2'b00) ||
             (last >= (WIDTH_ADD+1)'(SIZE));
   endfunction

   assign accept  = bus.req_valid && (state_q == IDLE);
   assign acc_err = req_error(bus.req_size, bus.req_addr);

   mem_lane_align #(.WIDTH(WIDTH)) u_align (
      .size        (size_q),
      .addr_lo     (lo_q),
      .is_unsigned (uns_q),
      .word        (bus.dc_rdata),
      .wdata       (wdata_q),
      .merged      (merged),
      .rdata       (extracted)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            if (acc_err)                                   state_d = RESP;
            else if (bus.req_write && bus.req_size == SZ_WORD) state_d = WR;
            else                                           state_d = RD;
         end
         RD:      state_d = wr_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q       <= 1'b0;
         uns_q      <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'd0;
         lo_q       <= 2'd0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         dc_wdata_q <= '0;
         dc_addr_q  <= '0;
      end else begin
         if (accept) begin
            wr_q    <= bus.req_write;
            uns_q   <= bus.req_unsigned;
            err_q   <= acc_err;
            size_q  <= bus.req_size;
            lo_q    <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            // Rejected requests leave the cache-side outputs untouched.
            if (!acc_err) begin
               dc_addr_q <= {bus.req_addr[WIDTH_ADD-1:2], 2'b00};
               if (bus.req_write && bus.req_size == SZ_WORD) dc_wdata_q <= bus.req_wdata;
            end
         end
         if (state_q == RD) begin
            if (wr_q) dc_wdata_q <= merged;
            else      rdata_q    <= extracted;
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.dc_we      = (state_q == WR);
   assign bus.dc_addr    = dc_addr_q;
   assign bus.dc_wdata   = dc_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset and back-to-back
// sequences, then random requests against a byte-array reference model.
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int SZ_LIM = 28;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_clear = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if #(.WIDTH(32), .WIDTH_ADD(32)) bus ();

   mem_access_unit #(.WIDTH(32), .WIDTH_ADD(32), .SIZE(SZ_LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Cache model: combinational read, write committed on the clock edge.
   logic [7:0] cmem [32];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) cmem[i] <= 8'h00;
      end else if (bus.dc_we) begin
         for (int i = 0; i < 4; i++) cmem[int'({bus.dc_addr[4:2], 2'b00}) + i] <= bus.dc_wdata[8*i +: 8];
      end
   end

   always_comb begin
      logic [4:0] b;
      b = {bus.dc_addr[4:2], 2'b00};
      bus.dc_rdata = {cmem[b+5'd3], cmem[b+5'd2], cmem[b+5'd1], cmem[b]};
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
   endtask

   // Reference model: flat byte memory and the access rules in plain arithmetic.
   logic [7:0] ref_mem [32];

   task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic [31:0] we_d);
      int ai, base, n;
      logic [31:0] v;
      ai = int'(a);
      base = ai - (ai % 4);
      n = 1 << sz;
      rd = '0;
      we_d = '0;
      er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && (ai % 4) != 0) || (base + 3 >= SZ_LIM);
      if (er) begin
         lat = 1;
      end else if (w) begin
         for (int i = 0; i < n; i++) ref_mem[ai+i] = wd[8*i +: 8];
         for (int i = 0; i < 4; i++) we_d[8*i +: 8] = ref_mem[base+i];
         lat = (sz == 2'd2) ? 2 : 3;
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ai+i]) << (8*i));
         if (!u && sz != 2'd2 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         rd = v;
         lat = 2;
      end
   endtask

   task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd);
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
   endtask

   task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int we_cnt, output logic [31:0] we_a,
                          output logic [31:0] we_d, output int busy, output logic pulse_ok);
      int guard;
      rd = '0; er = 1'b0; lat = 99; we_cnt = 0; we_a = '0; we_d = '0; busy = 0; pulse_ok = 1'b0;
      @(negedge clk);
      drive_req(w, sz, u, a, wd);
      bus.req_valid = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.dc_we) begin
            we_cnt++;
            we_a = bus.dc_addr;
            we_d = bus.dc_wdata;
         end
         if (!bus.req_ready) busy++;
         if (bus.resp_valid) begin
            rd = bus.resp_rdata;
            er = bus.resp_err;
            lat = c;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      pulse_ok = !bus.resp_valid;
   endtask

   task automatic apply_and_check(input string nm, input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                                  input logic exp_er, input int exp_lat, input logic [31:0] exp_wd);
      logic [31:0] rd, we_a, we_d;
      logic er, pulse_ok, exp_we;
      int lat, we_cnt, busy;
      run_req(w, sz, u, a, wd, rd, er, lat, we_cnt, we_a, we_d, busy, pulse_ok);
      exp_we = w && !exp_er;
      check({nm, " rdata"}, rd, exp_rd);
      check({nm, " err"}, {31'b0, er}, {31'b0, exp_er});
      check({nm, " latency"}, 32'(lat), 32'(exp_lat));
      check({nm, " ready-low cycles"}, 32'(busy), 32'(exp_lat));
      check({nm, " single resp pulse"}, {31'b0, pulse_ok}, 32'd1);
      check({nm, " dc_we cycles"}, 32'(we_cnt), exp_we ? 32'd1 : 32'd0);
      if (exp_we) begin
         check({nm, " dc_addr"}, we_a, {a[31:2], 2'b00});
         check({nm, " dc_wdata"}, we_d, exp_wd);
      end
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        eer;
      int          elat;
      logic [31:0] ewd;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] m_rd, m_wd;
      logic m_er, pending;
      int m_lat, k, n_acc;
      logic [31:0] exp_q[$];
      logic [31:0] got_q[$];
      vec_t b2b[3];
      int rv_cnt;

      bus.req_valid = 1'b0;
      drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("reset resp_err", {31'b0, bus.resp_err}, 32'd0);
      check("reset resp_rdata", bus.resp_rdata, 32'd0);
      check("reset dc_addr", bus.dc_addr, 32'd0);
      check("reset dc_wdata", bus.dc_wdata, 32'd0);
      check("reset dc_we", {31'b0, bus.dc_we}, 32'd0);
      mem_clear = 1'b0;
      rst_n = 1'b1;

      //              w     sz       u     addr   wdata          exp rdata      err  lat  exp dc_wdata
      tbl.push_back('{1'b1, SZ_WORD, 1'b0, 32'd4,  32'h1122_3344, 32'h0,         1'b0, 2, 32'h1122_3344});
      tbl.push_back('{1'b1, SZ_WORD, 1'b0, 32'd12, 32'h80F0_017F, 32'h0,         1'b0, 2, 32'h80F0_017F});
      tbl.push_back('{1'b1, SZ_WORD, 1'b0, 32'd8,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF});
      tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'd8,  32'h0,         32'hDEAD_BEEF, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b1, SZ_BYTE, 1'b0, 32'd6,  32'hFFFF_FFAA, 32'h0,         1'b0, 3, 32'h11AA_3344});
      tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'd4,  32'h0,         32'h11AA_3344, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_BYTE, 1'b0, 32'd12, 32'h0,         32'h0000_007F, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_BYTE, 1'b0, 32'd13, 32'h0,         32'h0000_0001, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_BYTE, 1'b0, 32'd14, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_HALF, 1'b1, 32'd14, 32'h0,         32'h0000_80F0, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_HALF, 1'b0, 32'd14, 32'h0,         32'hFFFF_80F0, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_BYTE, 1'b1, 32'd15, 32'h0,         32'h0000_0080, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b1, SZ_HALF, 1'b0, 32'd10, 32'h1234_CAFE, 32'h0,         1'b0, 3, 32'hCAFE_BEEF});
      tbl.push_back('{1'b0, SZ_HALF, 1'b0, 32'd10, 32'h0,         32'hFFFF_CAFE, 1'b0, 2, 32'h0});
      tbl.push_back('{1'b0, SZ_HALF, 1'b0, 32'd5,  32'h0,         32'h0,         1'b1, 1, 32'h0});
      tbl.push_back('{1'b1, SZ_WORD, 1'b0, 32'd2,  32'h9999_9999, 32'h0,         1'b1, 1, 32'h0});
      tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'd28, 32'h0,         32'h0,         1'b1, 1, 32'h0});
      tbl.push_back('{1'b0, 2'd3,    1'b0, 32'd0,  32'h0,         32'h0,         1'b1, 1, 32'h0});
      tbl.push_back('{1'b1, SZ_BYTE, 1'b0, 32'd26, 32'h0000_005A, 32'h0,         1'b0, 3, 32'h005A_0000});
      tbl.push_back('{1'b1, SZ_BYTE, 1'b0, 32'd29, 32'h0000_0077, 32'h0,         1'b1, 1, 32'h0});

      foreach (tbl[i]) begin
         model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, m_rd, m_er, m_lat, m_wd);
         apply_and_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                         tbl[i].erd, tbl[i].eer, tbl[i].elat, tbl[i].ewd);
      end

      // Reset while a sub-word store sits in RD.
      @(negedge clk);
      drive_req(1'b1, SZ_BYTE, 1'b0, 32'd4, 32'h0000_0077);
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("midrst dc_addr in RD", bus.dc_addr, 32'd4);
      check("midrst busy in RD", {31'b0, bus.req_ready}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("midrst dc_we", {31'b0, bus.dc_we}, 32'd0);
      check("midrst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("midrst dc_addr", bus.dc_addr, 32'd0);
      check("midrst dc_wdata", bus.dc_wdata, 32'd0);
      check("midrst resp_rdata", bus.resp_rdata, 32'd0);
      rv_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.resp_valid || bus.dc_we) rv_cnt++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.resp_valid || bus.dc_we) rv_cnt++;
      end
      check("midrst no resp or write", 32'(rv_cnt), 32'd0);
      model(1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, m_rd, m_er, m_lat, m_wd);
      apply_and_check("post-reset load", 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, m_rd, m_er, m_lat, m_wd);

      // Back-to-back loads with req_valid held high.
      b2b[0] = '{1'b0, SZ_WORD, 1'b0, 32'd4,  32'h0, 32'h0, 1'b0, 2, 32'h0};
      b2b[1] = '{1'b0, SZ_BYTE, 1'b0, 32'd14, 32'h0, 32'h0, 1'b0, 2, 32'h0};
      b2b[2] = '{1'b0, SZ_HALF, 1'b0, 32'd10, 32'h0, 32'h0, 1'b0, 2, 32'h0};
      for (int i = 0; i < 3; i++) begin
         model(b2b[i].w, b2b[i].sz, b2b[i].u, b2b[i].a, b2b[i].wd, m_rd, m_er, m_lat, m_wd);
         exp_q.push_back(m_rd);
      end
      @(negedge clk);
      k = 0;
      n_acc = 0;
      pending = 1'b0;
      drive_req(b2b[0].w, b2b[0].sz, b2b[0].u, b2b[0].a, b2b[0].wd);
      bus.req_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (bus.resp_valid) got_q.push_back(bus.resp_rdata);
         if (pending) begin
            k++;
            if (k < 3) drive_req(b2b[k].w, b2b[k].sz, b2b[k].u, b2b[k].a, b2b[k].wd);
            else bus.req_valid = 1'b0;
         end
         pending = bus.req_valid && bus.req_ready;
         if (pending) n_acc++;
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      check("b2b accepted count", 32'(n_acc), 32'd3);
      check("b2b resp count", 32'(got_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b resp%0d", i), (i < got_q.size()) ? got_q[i] : 32'hXXXX_XXXX, exp_q[i]);
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic w, u;
         logic [1:0] sz;
         logic [31:0] a, wd;
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 31));
         wd = $urandom;
         model(w, sz, u, a, wd, m_rd, m_er, m_lat, m_wd);
         apply_and_check($sformatf("rnd%0d", i), w, sz, u, a, wd, m_rd, m_er, m_lat, m_wd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
